regfile_window_reader: RTL

//  Read-side master for the convolution register file: on a start request it fetches DEPTH words
//  one at a time via RdEn/Address and collects them on RdData/RdData_valid.
//  It then presents them as one packed tap window to the MAC array, using a valid/ready handshake.

---
 rtl/regfile_window_reader_pkg.sv | 29 ++
 rtl/regfile_window_reader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_window_reader_pkg.sv
// Shared convolution definitions: default geometry of the register file,
// window reader FSM encoding and the tap slice helper used by the MAC array.
package regfile_window_reader_pkg;

    // Default geometry of the convolution register file
    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 5;
    localparam int ADDR_DEF    = 3;
    localparam int TIMEOUT_DEF = 15;

    // Window reader FSM encoding (kept as plain constants for legacy tools)
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] stateT;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    // Packed window type at default geometry
    typedef logic [DEPTH_DEF*WIDTH_DEF-1:0] windowT;
    typedef logic [WIDTH_DEF-1:0]           tapT;

    // Extract tap k from a packed window; tap0 sits in the least significant word
    function automatic tapT getTap(input windowT win, input int k);
        return win[k*WIDTH_DEF +: WIDTH_DEF];
    endfunction

endpackage

// File: rtl/regfile_window_reader.sv
// Read-side master for the convolution register file. On a start request it
// fetches DEPTH words one at a time (one read outstanding), beginning at a
// programmable address and wrapping circularly, then presents them as one
// packed tap window with a valid/ready handshake.
module regfile_window_reader
    import regfile_window_reader_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR    = ADDR_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR-1:0]        start_addr,
    output logic                   RdEn,
    output logic [ADDR-1:0]        Address,
    input  logic [WIDTH-1:0]       RdData,
    input  logic                   RdData_valid,
    output logic [DEPTH*WIDTH-1:0] win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // Highest legal register file address; anything above is rejected at start
    localparam logic [ADDR-1:0]  LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    // Value of the wait timer in the last cycle before a read is declared lost
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

    stateT            stateReg, stateNext;
    logic [ADDR-1:0]  ptrReg, ptrNext;
    logic [IDX_W-1:0] idxReg, idxNext;
    logic [TMR_W-1:0] timerReg, timerNext;
    logic             errReg, errNext;
    logic             capture;

    // Read data is only meaningful while a read is outstanding
    assign capture = (stateReg == ST_WAIT) && RdData_valid;

    // Next-state logic: sequencing of reads, wrap of the read pointer and timeout
    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        idxNext   = idxReg;
        timerNext = timerReg;
        errNext   = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (start) begin
                    if (start_addr <= LAST_ADDR) begin
                        ptrNext   = start_addr;
                        idxNext   = '0;
                        stateNext = ST_ISSUE;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                timerNext = '0;
                stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (RdData_valid) begin
                    if (idxReg == LAST_IDX) begin
                        stateNext = ST_PRESENT;
                    end else begin
                        idxNext   = idxReg + IDX_W'(1);
                        ptrNext   = (ptrReg == LAST_ADDR) ? '0 : ptrReg + ADDR'(1);
                        stateNext = ST_ISSUE;
                    end
                end else if (timerReg == LAST_TICK) begin
                    // Read lost: abandon the partial window without presenting it
                    errNext   = 1'b1;
                    stateNext = ST_IDLE;
                end else begin
                    timerNext = timerReg + TMR_W'(1);
                end
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            ptrReg   <= '0;
            idxReg   <= '0;
            timerReg <= '0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
            idxReg   <= idxNext;
            timerReg <= timerNext;
            errReg   <= errNext;
        end
    end

    // One storage word per tap; each captures only when its index is being fetched,
    // so the previous window stays visible until overwritten tap by tap
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [WIDTH-1:0] tapReg;

            // Capture the returned word into this tap slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    tapReg <= '0;
                end else if (capture && (idxReg == IDX_W'(gi))) begin
                    tapReg <= RdData;
                end
            end

            assign win_data[gi*WIDTH +: WIDTH] = tapReg;
        end
    endgenerate

    // Outputs decoded from the registered state; Address is zero when no read is issued
    assign RdEn      = (stateReg == ST_ISSUE);
    assign Address   = RdEn ? ptrReg : '0;
    assign win_valid = (stateReg == ST_PRESENT);
    assign busy      = (stateReg != ST_IDLE);
    assign err       = errReg;

endmodule
